rgb_mixer_multi: RTL and testbench

//  Parametrised N-channel encoder-driven PWM mixer; generalises the 3-channel 8-bit RGB mixer.

---
 rtl/rgb_mixer_multi_pkg.sv | 20 ++
 rtl/rgb_mixer_multi_if.sv | 33 +++
 rtl/rgb_mixer_multi_channel.sv | 114 +++++++++++
 rtl/rgb_mixer_multi.sv | 81 ++++++++
 tb/tb_rgb_mixer_multi.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_mixer_multi_pkg.sv
// rgb_mixer_multi_pkg
//   Shared definitions for the N-channel encoder-driven PWM mixer: default parameter
//   values and the per-detent decode action type.
package rgb_mixer_multi_pkg;

    localparam int unsigned DefChannels = 3;
    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefDivLog2  = 8;
    localparam int unsigned DefHistLen  = 8;
    localparam int unsigned DefStep     = 1;
    localparam bit          DefSaturate = 1'b1;

    // Action taken on a tick after looking at the debounced quadrature pair.
    typedef enum logic [1:0] {
        DecHold,
        DecUp,
        DecDown
    } dec_e;

endpackage

// File: rtl/rgb_mixer_multi_if.sv
// rgb_mixer_multi_if
//   Groups the mixer's user-facing signals.
//   enca/encb : async quadrature inputs, bit i = channel i
//   clear     : one-cycle pulse, zeroes every level
//   mute      : level-sensitive, forces all PWM outputs low
//   pwm_out   : per-channel PWM outputs
//   level     : flattened levels, channel i at [WIDTH*i +: WIDTH]
//   tick      : divider strobe
//   master drives the encoders/controls, slave is the mixer.
interface rgb_mixer_multi_if
    import rgb_mixer_multi_pkg::*;
#(
    parameter int unsigned CHANNELS = DefChannels,
    parameter int unsigned WIDTH    = DefWidth
);
    logic [CHANNELS-1:0]       enca;
    logic [CHANNELS-1:0]       encb;
    logic                      clear;
    logic                      mute;
    logic [CHANNELS-1:0]       pwm_out;
    logic [CHANNELS*WIDTH-1:0] level;
    logic                      tick;

    modport master (
        output enca, encb, clear, mute,
        input  pwm_out, level, tick
    );

    modport slave (
        input  enca, encb, clear, mute,
        output pwm_out, level, tick
    );
endinterface

// File: rtl/rgb_mixer_multi_channel.sv
// rgb_mixer_multi_channel
//   One encoder/PWM channel: 2-FF synchroniser and tick-rate debounce on A/B, x1
//   quadrature decode to a WIDTH-bit level, period-aligned duty shadow and PWM compare.
//   clk12MHz/reset : system clock, synchronous active-high reset
//   tick_i         : shared one-cycle enable from the divider
//   cnt_i          : shared PWM counter
//   clear_i/mute_i : global clear pulse / output mute
//   enca_i/encb_i  : raw asynchronous encoder inputs
//   level_o        : current level
//   pwm_o          : registered PWM output
module rgb_mixer_multi_channel
    import rgb_mixer_multi_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned HIST_LEN = DefHistLen,
    parameter bit          SATURATE = DefSaturate,
    parameter int unsigned STEP     = DefStep
) (
    input  logic             clk12MHz,
    input  logic             reset,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             clear_i,
    input  logic             mute_i,
    input  logic             enca_i,
    input  logic             encb_i,
    output logic [WIDTH-1:0] level_o,
    output logic             pwm_o
);

    localparam logic [WIDTH:0] StepW = STEP[WIDTH:0];

    // Index 0 is encoder A, index 1 is encoder B throughout.
    logic [1:0]               sync1_q, sync2_q;
    logic [1:0][HIST_LEN-1:0] hist_q, hist_d;
    logic [1:0]               deb_q, deb_d;
    logic [WIDTH-1:0]         level_q, level_d;
    logic [WIDTH-1:0]         duty_q, duty_d;
    logic                     pwm_q, pwm_d;
    logic [WIDTH:0]           up_sum, dn_diff;
    dec_e                     dec;

    // One guard bit: carry out flags overflow, borrow out flags underflow.
    assign up_sum  = {1'b0, level_q} + StepW;
    assign dn_diff = {1'b0, level_q} - StepW;

    always_comb begin
        hist_d = hist_q;
        deb_d  = deb_q;
        if (tick_i) begin
            for (int k = 0; k < 2; k++) begin
                hist_d[k] = {hist_q[k][HIST_LEN-2:0], sync2_q[k]};
                if (&hist_d[k]) begin
                    deb_d[k] = 1'b1;
                end else if (!(|hist_d[k])) begin
                    deb_d[k] = 1'b0;
                end
            end
        end
    end

    // Count only on the debounced A rising edge; B as seen on that same tick gives direction.
    always_comb begin
        dec = DecHold;
        if (tick_i && deb_d[0] && !deb_q[0]) begin
            dec = deb_d[1] ? DecDown : DecUp;
        end
    end

    always_comb begin
        level_d = level_q;
        case (dec)
            DecUp:   level_d = (SATURATE && up_sum[WIDTH]) ? '1 : up_sum[WIDTH-1:0];
            DecDown: level_d = (SATURATE && dn_diff[WIDTH]) ? '0 : dn_diff[WIDTH-1:0];
            default: level_d = level_q;
        endcase
        if (clear_i) begin
            level_d = '0;
        end
    end

    // Shadow the level on the last slot so the new duty takes effect from cnt == 0.
    always_comb begin
        duty_d = duty_q;
        if (tick_i && (&cnt_i)) begin
            duty_d = level_q;
        end
        pwm_d = (cnt_i < duty_q) && !mute_i;
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            deb_q   <= '0;
            level_q <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            sync1_q <= {encb_i, enca_i};
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            deb_q   <= deb_d;
            level_q <= level_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
        end
    end

    assign level_o = level_q;
    assign pwm_o   = pwm_q;

endmodule

// File: rtl/rgb_mixer_multi.sv
// rgb_mixer_multi
//   N-channel encoder-driven PWM mixer. Holds the tick divider and the shared PWM counter
//   and fans clear/mute out to one rgb_mixer_multi_channel per channel, so all PWM edges
//   are phase-aligned.
//   clk12MHz : system clock
//   reset    : synchronous, active-high
//   mix_io   : slave side of rgb_mixer_multi_if (encoders, clear, mute, pwm, level, tick)
module rgb_mixer_multi
    import rgb_mixer_multi_pkg::*;
#(
    parameter int unsigned CHANNELS = DefChannels,
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DIV_LOG2 = DefDivLog2,
    parameter int unsigned HIST_LEN = DefHistLen,
    parameter bit          SATURATE = DefSaturate,
    parameter int unsigned STEP     = DefStep
) (
    input logic                clk12MHz,
    input logic                reset,
    rgb_mixer_multi_if.slave   mix_io
);

    logic [DIV_LOG2-1:0] div_q, div_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                tick;
    logic [WIDTH-1:0]    ch_level [CHANNELS];
    logic                ch_pwm   [CHANNELS];

    // Tick is a clock enable, never a clock: high for the single cycle at all-ones.
    assign tick = &div_q;

    always_comb begin
        div_d = div_q + 1'b1;
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        rgb_mixer_multi_channel #(
            .WIDTH    (WIDTH),
            .HIST_LEN (HIST_LEN),
            .SATURATE (SATURATE),
            .STEP     (STEP)
        ) u_ch (
            .clk12MHz (clk12MHz),
            .reset    (reset),
            .tick_i   (tick),
            .cnt_i    (cnt_q),
            .clear_i  (mix_io.clear),
            .mute_i   (mix_io.mute),
            .enca_i   (mix_io.enca[i]),
            .encb_i   (mix_io.encb[i]),
            .level_o  (ch_level[i]),
            .pwm_o    (ch_pwm[i])
        );
    end

    always_comb begin
        mix_io.level   = '0;
        mix_io.pwm_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mix_io.level[WIDTH*i +: WIDTH] = ch_level[i];
            mix_io.pwm_out[i]              = ch_pwm[i];
        end
    end

    assign mix_io.tick = tick;

endmodule

// File: tb/tb_rgb_mixer_multi.sv
// tb_rgb_mixer_multi
//   Two mixers on one clock: u_dut_n (saturating, STEP=1) and u_dut_w (wrapping, STEP=16),
//   both CHANNELS=3, WIDTH=8, DIV_LOG2=2, HIST_LEN=4. Levels are predicted by a plain
//   arithmetic model per detent; duty is checked by counting high cycles over a full period.
module tb_rgb_mixer_multi;

    localparam int TickCyc   = 4;
    localparam int HoldCyc   = 6 * TickCyc;
    localparam int PeriodCyc = 256 * TickCyc;
    localparam int SettleCyc = PeriodCyc + 80;

    logic clk12MHz = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   mdl_n [3];
    int   mdl_w [3];

    always #5 clk12MHz = ~clk12MHz;

    rgb_mixer_multi_if #(.CHANNELS(3), .WIDTH(8)) bus_n ();
    rgb_mixer_multi_if #(.CHANNELS(3), .WIDTH(8)) bus_w ();

    rgb_mixer_multi #(
        .CHANNELS(3), .WIDTH(8), .DIV_LOG2(2), .HIST_LEN(4), .SATURATE(1'b1), .STEP(1)
    ) u_dut_n (
        .clk12MHz (clk12MHz),
        .reset    (reset),
        .mix_io   (bus_n.slave)
    );

    rgb_mixer_multi #(
        .CHANNELS(3), .WIDTH(8), .DIV_LOG2(2), .HIST_LEN(4), .SATURATE(1'b0), .STEP(16)
    ) u_dut_w (
        .clk12MHz (clk12MHz),
        .reset    (reset),
        .mix_io   (bus_w.slave)
    );

    function automatic int ref_step(input int lvl, input bit ccw, input int step,
                                    input bit sat);
        int n;
        n = ccw ? lvl - step : lvl + step;
        if (sat) begin
            if (n > 255) n = 255;
            if (n < 0) n = 0;
        end else begin
            n = ((n % 256) + 256) % 256;
        end
        return n;
    endfunction

    function automatic int lvl_of(input bit wide, input int ch);
        return wide ? int'(bus_w.level[8*ch +: 8]) : int'(bus_n.level[8*ch +: 8]);
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk12MHz);
    endtask

    task automatic set_a(input bit wide, input int ch, input logic v);
        if (wide) bus_w.enca[ch] = v;
        else      bus_n.enca[ch] = v;
    endtask

    task automatic set_b(input bit wide, input int ch, input logic v);
        if (wide) bus_w.encb[ch] = v;
        else      bus_n.encb[ch] = v;
    endtask

    // One detent: B settles first if it must change, then A pulses high and low.
    task automatic detent(input bit wide, input int ch, input bit ccw);
        logic cur_b;
        cur_b = wide ? bus_w.encb[ch] : bus_n.encb[ch];
        if (cur_b !== ccw) begin
            set_b(wide, ch, ccw);
            wait_cyc(HoldCyc);
        end
        set_a(wide, ch, 1'b1);
        wait_cyc(HoldCyc);
        set_a(wide, ch, 1'b0);
        wait_cyc(HoldCyc);
        if (wide) mdl_w[ch] = ref_step(mdl_w[ch], ccw, 16, 1'b0);
        else      mdl_n[ch] = ref_step(mdl_n[ch], ccw, 1, 1'b1);
    endtask

    task automatic count_high(input bit wide, input int ch, input int ncyc, output int hi);
        hi = 0;
        repeat (ncyc) begin
            wait_cyc(1);
            if (wide ? bus_w.pwm_out[ch] : bus_n.pwm_out[ch]) hi++;
        end
    endtask

    task automatic test_reset();
        int tk;
        reset = 1'b1;
        bus_n.enca = '0; bus_n.encb = '0; bus_n.clear = 1'b0; bus_n.mute = 1'b0;
        bus_w.enca = '0; bus_w.encb = '0; bus_w.clear = 1'b0; bus_w.mute = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mdl_n[i] = 0;
            mdl_w[i] = 0;
        end
        wait_cyc(1);
        for (int c = 0; c < 3; c++) begin
            bus_n.enca = 3'($urandom);
            bus_n.encb = 3'($urandom);
            wait_cyc(1);
            n_cmp++;
            if (bus_n.pwm_out !== 3'b000 || bus_n.level !== 24'h0 || bus_n.tick !== 1'b0) begin
                n_err++;
                $display("FAIL reset cyc%0d: pwm=%b level=%h tick=%b, want 000/000000/0",
                         c, bus_n.pwm_out, bus_n.level, bus_n.tick);
            end
        end
        n_cmp++;
        if (bus_w.level !== 24'h0 || bus_w.pwm_out !== 3'b000) begin
            n_err++;
            $display("FAIL reset_wide: level=%h pwm=%b, want 0", bus_w.level, bus_w.pwm_out);
        end
        bus_n.enca = '0;
        bus_n.encb = '0;
        wait_cyc(1);
        reset = 1'b0;
        count_high(1'b0, 0, 0, tk);
        tk = 0;
        repeat (16) begin
            wait_cyc(1);
            if (bus_n.tick) tk++;
        end
        n_cmp++;
        if (tk != 4) begin
            n_err++;
            $display("FAIL tick_rate: %0d ticks in 16 cycles, want 4", tk);
        end
    endtask

    task automatic test_cw_ch1();
        int hi;
        for (int d = 0; d < 5; d++) detent(1'b0, 1, 1'b0);
        for (int ch = 0; ch < 3; ch++) begin
            n_cmp++;
            if (lvl_of(1'b0, ch) != mdl_n[ch]) begin
                n_err++;
                $display("FAIL cw_ch1 level[%0d]: got %0d want %0d", ch, lvl_of(1'b0, ch),
                         mdl_n[ch]);
            end
        end
        wait_cyc(SettleCyc);
        count_high(1'b0, 1, PeriodCyc, hi);
        n_cmp++;
        if (hi != 4 * mdl_n[1]) begin
            n_err++;
            $display("FAIL cw_ch1 duty: %0d high cycles, want %0d", hi, 4 * mdl_n[1]);
        end
    endtask

    task automatic test_saturation();
        int hi;
        detent(1'b0, 0, 1'b1);
        n_cmp++;
        if (lvl_of(1'b0, 0) != mdl_n[0] || mdl_n[0] != 0) begin
            n_err++;
            $display("FAIL sat_low: got %0d want 0", lvl_of(1'b0, 0));
        end
        for (int d = 0; d < 260; d++) detent(1'b0, 0, 1'b0);
        n_cmp++;
        if (lvl_of(1'b0, 0) != mdl_n[0]) begin
            n_err++;
            $display("FAIL sat_high: got %0d want %0d", lvl_of(1'b0, 0), mdl_n[0]);
        end
        wait_cyc(SettleCyc);
        count_high(1'b0, 0, PeriodCyc, hi);
        n_cmp++;
        if (hi != 4 * 255) begin
            n_err++;
            $display("FAIL sat_duty: %0d high cycles, want %0d", hi, 4 * 255);
        end
    endtask

    task automatic test_bounce();
        for (int g = 2; g <= 3; g++) begin
            set_a(1'b0, 2, 1'b1);
            wait_cyc(g * TickCyc);
            set_a(1'b0, 2, 1'b0);
            wait_cyc(HoldCyc);
            n_cmp++;
            if (lvl_of(1'b0, 2) != mdl_n[2]) begin
                n_err++;
                $display("FAIL bounce_%0dticks: got %0d want %0d", g, lvl_of(1'b0, 2),
                         mdl_n[2]);
            end
        end
        set_a(1'b0, 2, 1'b1);
        wait_cyc(4 * TickCyc);
        set_a(1'b0, 2, 1'b0);
        wait_cyc(HoldCyc);
        mdl_n[2] = ref_step(mdl_n[2], 1'b0, 1, 1'b1);
        n_cmp++;
        if (lvl_of(1'b0, 2) != mdl_n[2]) begin
            n_err++;
            $display("FAIL bounce_stable: got %0d want %0d", lvl_of(1'b0, 2), mdl_n[2]);
        end
    endtask

    task automatic test_random();
        int ch;
        bit ccw;
        for (int d = 0; d < 24; d++) begin
            ch  = int'($urandom_range(2, 0));
            ccw = 1'($urandom);
            detent(1'b0, ch, ccw);
            n_cmp++;
            if (lvl_of(1'b0, ch) != mdl_n[ch]) begin
                n_err++;
                $display("FAIL random d%0d ch%0d: got %0d want %0d", d, ch, lvl_of(1'b0, ch),
                         mdl_n[ch]);
            end
        end
    endtask

    task automatic test_mute();
        int hi;
        int lo_err;
        wait_cyc(SettleCyc);
        count_high(1'b0, 0, PeriodCyc, hi);
        n_cmp++;
        if (hi != 4 * mdl_n[0]) begin
            n_err++;
            $display("FAIL pre_mute duty: %0d high cycles, want %0d", hi, 4 * mdl_n[0]);
        end
        bus_n.mute = 1'b1;
        wait_cyc(1);
        n_cmp++;
        if (bus_n.pwm_out !== 3'b000) begin
            n_err++;
            $display("FAIL mute_next_cycle: pwm=%b want 000", bus_n.pwm_out);
        end
        lo_err = 0;
        repeat (64) begin
            wait_cyc(1);
            if (bus_n.pwm_out !== 3'b000) lo_err++;
        end
        n_cmp++;
        if (lo_err != 0) begin
            n_err++;
            $display("FAIL mute_hold: %0d cycles with pwm high, want 0", lo_err);
        end
        for (int ch = 0; ch < 3; ch++) begin
            n_cmp++;
            if (lvl_of(1'b0, ch) != mdl_n[ch]) begin
                n_err++;
                $display("FAIL mute_level[%0d]: got %0d want %0d", ch, lvl_of(1'b0, ch),
                         mdl_n[ch]);
            end
        end
        bus_n.mute = 1'b0;
        wait_cyc(2);
        count_high(1'b0, 0, PeriodCyc, hi);
        n_cmp++;
        if (hi != 4 * mdl_n[0]) begin
            n_err++;
            $display("FAIL unmute duty: %0d high cycles, want %0d", hi, 4 * mdl_n[0]);
        end
    endtask

    // Pulse clear during the exact cycle in which ch2's fourth high history sample lands.
    task automatic test_clear();
        int  seen;
        bit  hit;
        if (bus_n.encb[2] !== 1'b0) begin
            set_b(1'b0, 2, 1'b0);
            wait_cyc(HoldCyc);
        end
        set_a(1'b0, 2, 1'b1);
        wait_cyc(2);
        seen = 0;
        hit  = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (bus_n.tick) seen++;
            if (seen == 4) begin
                bus_n.clear = 1'b1;
                wait_cyc(1);
                bus_n.clear = 1'b0;
                hit = 1'b1;
            end else begin
                wait_cyc(1);
            end
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL clear_sync: saw %0d ticks in 40 cycles, want 4", seen);
        end
        wait_cyc(HoldCyc);
        set_a(1'b0, 2, 1'b0);
        wait_cyc(HoldCyc);
        for (int ch = 0; ch < 3; ch++) begin
            mdl_n[ch] = 0;
            n_cmp++;
            if (lvl_of(1'b0, ch) != 0) begin
                n_err++;
                $display("FAIL clear_level[%0d]: got %0d want 0", ch, lvl_of(1'b0, ch));
            end
        end
    endtask

    task automatic test_wrap();
        int  hi;
        bit  found;
        logic prev;
        for (int d = 0; d < 15; d++) detent(1'b1, 0, 1'b0);
        n_cmp++;
        if (lvl_of(1'b1, 0) != 240 || mdl_w[0] != 240) begin
            n_err++;
            $display("FAIL wrap_240: got %0d want 240", lvl_of(1'b1, 0));
        end
        detent(1'b1, 0, 1'b0);
        n_cmp++;
        if (lvl_of(1'b1, 0) != mdl_w[0]) begin
            n_err++;
            $display("FAIL wrap_up: got %0d want %0d", lvl_of(1'b1, 0), mdl_w[0]);
        end
        detent(1'b1, 0, 1'b1);
        n_cmp++;
        if (lvl_of(1'b1, 0) != mdl_w[0]) begin
            n_err++;
            $display("FAIL wrap_down: got %0d want %0d", lvl_of(1'b1, 0), mdl_w[0]);
        end
        // ch0 at 240 rises at every period start; use it as the phase reference.
        wait_cyc(SettleCyc);
        found = 1'b0;
        for (int c = 0; c < SettleCyc && !found; c++) begin
            prev = bus_w.pwm_out[0];
            wait_cyc(1);
            if (!prev && bus_w.pwm_out[0]) found = 1'b1;
        end
        set_a(1'b1, 1, 1'b1);
        count_high(1'b1, 1, HoldCyc, hi);
        set_a(1'b1, 1, 1'b0);
        mdl_w[1] = ref_step(mdl_w[1], 1'b0, 16, 1'b0);
        for (int c = 0; c < HoldCyc; c++) begin
            wait_cyc(1);
            if (bus_w.pwm_out[1]) hi++;
        end
        n_cmp++;
        if (lvl_of(1'b1, 1) != mdl_w[1]) begin
            n_err++;
            $display("FAIL midperiod_level: got %0d want %0d", lvl_of(1'b1, 1), mdl_w[1]);
        end
        found = 1'b0;
        for (int c = 0; c < SettleCyc && !found; c++) begin
            prev = bus_w.pwm_out[0];
            wait_cyc(1);
            if (!prev && bus_w.pwm_out[0]) found = 1'b1;
            else if (bus_w.pwm_out[1]) hi++;
        end
        n_cmp++;
        if (!found || hi != 0) begin
            n_err++;
            $display("FAIL midperiod_hold: found=%0d early_high=%0d, want 1/0", found, hi);
        end
        n_cmp++;
        if (bus_w.pwm_out[1] !== 1'b1) begin
            n_err++;
            $display("FAIL midperiod_apply: pwm1=%b at period start, want 1",
                     bus_w.pwm_out[1]);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        wait_cyc(1);
        n_cmp++;
        if (bus_w.level !== 24'h0 || bus_w.pwm_out !== 3'b000 || bus_n.tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: level=%h pwm=%b tick=%b, want 0",
                     bus_w.level, bus_w.pwm_out, bus_n.tick);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cw_ch1();
        test_saturation();
        test_bounce();
        test_random();
        test_mute();
        test_clear();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
